// File: rtl/pipeline_ctrl.sv
// Hazard / stall / flush controller for a 5-stage in-order pipeline.
// Define PIPELINE_CTRL_PERF_CNT_EN to build the saturating perf counters.
module pipeline_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MemRead_EX,
    input  logic [4:0]           rd_EX,
    input  logic [4:0]           rs1_ID,
    input  logic [4:0]           rs2_ID,
    input  logic                 Branch_MEM,
    input  logic                 zero_flag_MEM,
    input  logic                 Jump_MEM,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 flush_IF_ID,
    output logic                 flush_ID_EX,
    output logic                 flush_EX_MEM,
    output logic                 flush_MEM_WB,
    output logic                 pc_sel,
    output logic                 mem_fault,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam int WCW = 10;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           taken;
    logic           load_use;
    logic           mem_stall;

    assign taken     = Jump_MEM | (Branch_MEM & zero_flag_MEM);
    assign load_use  = MemRead_EX && (rd_EX != 5'd0) &&
                       ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
    assign mem_stall = dmem_req & ~dmem_ready;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        pc_sel       = 1'b0;
        mem_fault    = 1'b0;
        if (!rst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB} = 4'b1111;
        end else if (state == FAULT) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            flush_MEM_WB = 1'b1;
            mem_fault    = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything; bubble into WB so nothing retires twice
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            flush_MEM_WB = 1'b1;
        end else if (taken) begin
            pc_sel       = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            flush_ID_EX = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // Ready on the last allowed cycle still wins
                    if (!mem_stall) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FAULT: state <= FAULT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic any_stall;

    assign any_stall = ~(pc_en & if_id_en & id_ex_en & ex_mem_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (any_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (pc_sel && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl (WAIT_TIMEOUT=4, 8-bit counters).
module tb_pipeline_ctrl;

    localparam int CW = 8;

    // {pc_en,if_id_en,id_ex_en,ex_mem_en,fIF,fID,fEX,fWB,pc_sel,mem_fault}
    localparam logic [9:0] RUNALL = 10'b1111_0000_0_0;
    localparam logic [9:0] LU     = 10'b0011_0100_0_0;
    localparam logic [9:0] TK     = 10'b1111_1110_1_0;
    localparam logic [9:0] MS     = 10'b0000_0001_0_0;
    localparam logic [9:0] FT     = 10'b0000_0001_0_1;
    localparam logic [9:0] RST    = 10'b0000_1111_0_0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          MemRead_EX = 1'b0;
    logic [4:0]    rd_EX = '0;
    logic [4:0]    rs1_ID = '0;
    logic [4:0]    rs2_ID = '0;
    logic          Branch_MEM = 1'b0;
    logic          zero_flag_MEM = 1'b0;
    logic          Jump_MEM = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
    logic          pc_sel, mem_fault;
    logic [CW-1:0] stall_cycles, flush_events;

    pipeline_ctrl #(.WAIT_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .Branch_MEM(Branch_MEM), .zero_flag_MEM(zero_flag_MEM),
        .Jump_MEM(Jump_MEM),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .pc_sel(pc_sel), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       br, z, j, req, rdy;
        logic [9:0] exp;
        string      nm;
    } vec_t;

    vec_t    vq[$];
    int      nvec = 0;
    int      nfail = 0;
    int      exp_stall = 0;
    int      exp_flush = 0;

    task automatic add(input string nm, input logic mr,
                       input logic [4:0] rd, rs1, rs2,
                       input logic br, z, j, req, rdy,
                       input logic [9:0] exp);
        vec_t v;
        v.nm = nm; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.br = br; v.z = z; v.j = j; v.req = req; v.rdy = rdy;
        v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, rs1, rs2,
                         input logic br, z, j, req, rdy);
        @(negedge clk);
        MemRead_EX = mr; rd_EX = rd; rs1_ID = rs1; rs2_ID = rs2;
        Branch_MEM = br; zero_flag_MEM = z; Jump_MEM = j;
        dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare now, then account for what the next rising edge will count
    task automatic check(input string nm, input logic [9:0] exp);
        logic [9:0]    act;
        logic [CW-1:0] es, ef;
        #2;
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, flush_IF_ID,
               flush_ID_EX, flush_EX_MEM, flush_MEM_WB, pc_sel, mem_fault};
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        es = CW'(exp_stall);
        ef = CW'(exp_flush);
`else
        es = '0;
        ef = '0;
`endif
        nvec++;
        if (act !== exp || stall_cycles !== es || flush_events !== ef) begin
            nfail++;
            $display("FAIL %s: outs=%b want %b stall=%0d want %0d flush=%0d want %0d",
                     nm, act, exp, stall_cycles, es, flush_events, ef);
        end
        if (rst_n && exp[9:6] != 4'hF && exp_stall < 255) exp_stall++;
        if (rst_n && exp[1] && exp_flush < 255) exp_flush++;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        add("idle",       0,  0,  0,  0, 0, 0, 0, 0, 0, RUNALL);
        add("lu_rs1",     1,  3,  3,  7, 0, 0, 0, 0, 0, LU);
        add("lu_rs2",     1,  5,  1,  5, 0, 0, 0, 0, 0, LU);
        add("x0",         1,  0,  0,  0, 0, 0, 0, 0, 0, RUNALL);
        add("no_memrd",   0,  5,  5,  5, 0, 0, 0, 0, 0, RUNALL);
        add("rd_miss",    1,  5,  4,  6, 0, 0, 0, 0, 0, RUNALL);
        add("br_taken",   0,  0,  0,  0, 1, 1, 0, 0, 0, TK);
        add("br_nt",      0,  0,  0,  0, 1, 0, 0, 0, 0, RUNALL);
        add("zero_only",  0,  0,  0,  0, 0, 1, 0, 0, 0, RUNALL);
        add("jump",       0,  0,  0,  0, 0, 0, 1, 0, 0, TK);
        add("br_over_lu", 1,  5,  0,  5, 1, 1, 0, 0, 0, TK);
        add("jmp_over_lu",1, 31, 31,  0, 0, 0, 1, 0, 0, TK);
        add("req_ready",  0,  0,  0,  0, 0, 0, 0, 1, 1, RUNALL);
        add("req_rdy_lu", 1,  2,  2,  9, 0, 0, 0, 1, 1, LU);
        add("rdy_no_req", 0,  0,  0,  0, 0, 0, 1, 0, 1, TK);
        add("lu_r31",     1, 31, 31, 31, 0, 0, 0, 0, 0, LU);

        idle();
        check("reset", RST);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset", RUNALL);

        foreach (vq[i]) begin
            drive(vq[i].mr, vq[i].rd, vq[i].rs1, vq[i].rs2,
                  vq[i].br, vq[i].z, vq[i].j, vq[i].req, vq[i].rdy);
            check(vq[i].nm, vq[i].exp);
        end

        // Load-use: one bubble, then the bubble in EX clears the hazard
        drive(1, 5, 0, 5, 0, 0, 0, 0, 0);
        check("lu_seq_stall", LU);
        drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
        check("lu_seq_release", RUNALL);

        // Memory wait: three not-ready cycles, release on ready cycle
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            check("memwait_stall", MS);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("memwait_release", RUNALL);

        // Stall outranks a taken branch
        drive(1, 5, 5, 0, 1, 1, 0, 1, 0);
        check("stall_over_taken", MS);
        drive(0, 0, 0, 0, 1, 1, 0, 1, 1);
        check("release_taken", TK);

        // Ready arriving on the final allowed wait cycle wins
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            check("edge_stall", MS);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("edge_ready_wins", RUNALL);
        idle();
        check("edge_no_fault", RUNALL);

        // Timeout: entry cycle plus four waits, then FAULT
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            check("to_stall", MS);
        end
        drive(1, 5, 5, 5, 1, 1, 1, 1, 1);
        check("fault_entry", FT);
        for (int i = 0; i < 260; i++) begin
            idle();
            check("fault_hold", FT);
        end

        reset_pulse();
        check("fault_reset", RST);
        @(negedge clk);
        rst_n = 1'b1;
        check("fault_cleared", RUNALL);

        // Reset in the middle of a memory wait
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("mid_stall0", MS);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("mid_stall1", MS);
        reset_pulse();
        check("mid_reset", RST);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_req = 1'b0;
        check("mid_after", RUNALL);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("mid_restall", MS);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mid_req_drop", RUNALL);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before fault (1..1023).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of performance counters.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports MemRead_EX  input  1  and rd_EX  input  5  (EX-stage load and its destination).
REQ-006 SHALL have ports rs1_ID, rs2_ID  input  5 each  (ID-stage source registers).
REQ-007 SHALL have ports Branch_MEM, zero_flag_MEM, Jump_MEM  input  1 each  (MEM-stage control-flow resolution).
REQ-008 SHALL have ports dmem_req  input  1  (MEM stage accesses memory) and dmem_ready  input  1  (access completes this cycle).
REQ-009 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en  1 each  (register load enables, 1=advance).
REQ-010 SHALL have outputs flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  1 each  (load bubble on next edge).
REQ-011 SHALL have outputs pc_sel  1  (1=take MEM branch target) and mem_fault  1  (sticky timeout flag).
REQ-012 SHALL have outputs stall_cycles, flush_events  CNT_WIDTH each  (performance counters).

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, FAULT; all outputs combinational from state and inputs except counters.
REQ-014 SHALL define taken = Jump_MEM | (Branch_MEM & zero_flag_MEM); load_use = MemRead_EX & rd_EX!=0 & (rd_EX==rs1_ID | rd_EX==rs2_ID).
REQ-015 SHALL define mem_stall = dmem_req & !dmem_ready, evaluated in RUN and MEM_WAIT.
REQ-016 SHALL apply priority FAULT > mem_stall > taken > load_use; lower-priority conditions ignored that cycle.
REQ-017 SHALL, on mem_stall: all four enables 0, flush_MEM_WB=1, other flushes 0, pc_sel=0.
REQ-018 SHALL transition RUN->MEM_WAIT on mem_stall; MEM_WAIT->RUN on dmem_ready (same cycle releases enables, zero-latency).
REQ-019 SHALL count MEM_WAIT cycles in a wait counter cleared on entry; reaching WAIT_TIMEOUT with dmem_ready=0 SHALL go to FAULT.
REQ-020 SHALL, on dmem_ready in the exact cycle the counter reaches WAIT_TIMEOUT, return to RUN (ready wins).
REQ-021 SHALL, in FAULT: all enables 0, flush_MEM_WB=1, mem_fault=1; FAULT exited only by reset.
REQ-022 SHALL, on taken (no higher priority): pc_sel=1, flush_IF_ID=flush_ID_EX=flush_EX_MEM=1, all enables 1.
REQ-023 SHALL, on load_use (no higher priority): pc_en=0, if_id_en=0, flush_ID_EX=1, id_ex_en=ex_mem_en=1; exactly one bubble per hazard.
REQ-024 SHALL, with no condition active: all enables 1, all flushes 0, pc_sel=0.
REQ-025 SHALL treat rd_EX=0 as never hazardous (x0).

Reset
REQ-026 SHALL, while rst_n=0, force state RUN, wait counter 0, mem_fault 0, counters 0, all enables 0, all flushes 1, pc_sel 0.
REQ-027 SHALL, on rst_n deassertion, resume RUN on the next rising edge; reset mid-MEM_WAIT or FAULT returns to RUN.

Configuration
REQ-028 SHALL, with PIPELINE_CTRL_PERF_CNT_EN defined, increment stall_cycles each cycle any enable is 0 (outside reset) and flush_events each taken redirect, both saturating at all-ones.
REQ-029 SHALL, without PIPELINE_CTRL_PERF_CNT_EN, tie stall_cycles and flush_events to 0 with no counter flops; ports remain.

Verification
REQ-030 SHALL cover load-use: MemRead_EX=1, rd_EX=5, rs2_ID=5 -> one cycle pc_en=0, if_id_en=0, flush_ID_EX=1; next cycle all enables 1.
REQ-031 SHALL cover x0: MemRead_EX=1, rd_EX=0, rs1_ID=0 -> no stall, no flush.
REQ-032 SHALL cover branch: Branch_MEM=1, zero_flag_MEM=1, simultaneous load_use -> pc_sel=1, three flushes, no stall; flush_events +1.
REQ-033 SHALL cover memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> 3 cycles enables 0 / flush_MEM_WB=1, release on ready cycle; stall_cycles +3.
REQ-034 SHALL cover timeout: WAIT_TIMEOUT=4, dmem_ready held 0 -> FAULT, mem_fault=1 held until rst_n pulse clears it to 0.
REQ-035 SHALL cover reset mid-wait: rst_n low during MEM_WAIT -> all flushes 1, enables 0; after release RUN with counters 0.
